// File: rtl/spi_slave_core.sv
// SPI slave core: synchronizes the SPI bus into clk_i, shifts 8/16/24/32-bit
// frames in all four CPOL/CPHA modes, MSB- or LSB-first, with a one-entry
// transmit holding register and a one-entry receive output register.
module spi_slave_core (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dtb_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        busy_o,
  output logic        ovr_o,
  output logic        udr_o,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  // Bus synchronizers plus one extra stage on SCK/NSS for edge detection
  logic r_sck_m, r_sck_s, r_sck_d;
  logic r_nss_m, r_nss_s, r_nss_d;
  logic r_mosi_m, r_mosi_s;

  // Control state and configuration latched at frame start
  state_t      r_state;
  logic        r_cpol;
  logic        r_cpha;
  logic        r_lsb;
  logic [1:0]  r_dtb;

  // Datapath registers
  logic [5:0]  r_cnt;
  logic [31:0] r_tx_sh;
  logic        r_skip;
  logic [31:0] r_rx_sh;
  logic [31:0] r_hold;
  logic        r_full;
  logic        r_rx_valid;
  logic [31:0] r_rx_data;
  logic        r_ovr;
  logic        r_udr;

  logic        w_active;
  logic        w_start;
  logic        w_stop;
  logic        w_rise;
  logic        w_fall;
  logic        w_lead;
  logic        w_trail;
  logic        w_sample;
  logic        w_shift;
  logic        w_smp;
  logic        w_done;
  logic        w_load;
  logic [5:0]  w_nbits;
  logic [5:0]  w_cnt_nxt;
  logic [4:0]  w_msb_idx;
  logic [31:0] w_mask;
  logic [31:0] w_rx_nxt;
  logic [31:0] w_load_word;

  assign w_active  = (r_state == S_ACTIVE);
  // NSS falling edge starts a frame; NSS high or disable aborts/ends it
  assign w_start   = ~w_active & en_i & r_nss_d & ~r_nss_s;
  assign w_stop    = w_active & (r_nss_s | ~en_i);

  assign w_rise    = r_sck_s & ~r_sck_d;
  assign w_fall    = ~r_sck_s & r_sck_d;
  assign w_lead    = r_cpol ? w_fall : w_rise;
  assign w_trail   = r_cpol ? w_rise : w_fall;
  assign w_sample  = r_cpha ? w_trail : w_lead;
  assign w_shift   = r_cpha ? w_lead : w_trail;

  // Frame length N = 8*(dtb+1); index of the top frame bit is 8*dtb+7
  assign w_nbits   = ({4'd0, r_dtb} + 6'd1) << 3;
  assign w_msb_idx = {r_dtb, 3'b111};
  assign w_cnt_nxt = r_cnt + 6'd1;

  assign w_smp     = w_active & ~w_stop & w_sample;
  assign w_done    = w_smp & (w_cnt_nxt == w_nbits);
  assign w_load    = w_start | w_done;
  assign w_load_word = r_full ? r_hold : 32'd0;

  // Mask selecting the N valid bits of a received word
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    case (r_dtb)
      2'b00:   w_mask = 32'h0000_00FF;
      2'b01:   w_mask = 32'h0000_FFFF;
      2'b10:   w_mask = 32'h00FF_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Next RX shift value: MOSI enters at bit 0 (MSB-first) or bit N-1 (LSB-first)
  always_comb begin
    w_rx_nxt = {r_rx_sh[30:0], r_mosi_s};
    if (r_lsb) begin
      w_rx_nxt = {1'b0, r_rx_sh[31:1]};
      w_rx_nxt[w_msb_idx] = r_mosi_s;
    end
  end

  // Two-flop synchronizers; SCK resets to its idle level so no false edge follows reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sck_m  <= cpol_i;
      r_sck_s  <= cpol_i;
      r_sck_d  <= cpol_i;
      r_nss_m  <= 1'b1;
      r_nss_s  <= 1'b1;
      r_nss_d  <= 1'b1;
      r_mosi_m <= 1'b0;
      r_mosi_s <= 1'b0;
    end else begin
      r_sck_m  <= spi_sck_i;
      r_sck_s  <= r_sck_m;
      r_sck_d  <= r_sck_s;
      r_nss_m  <= spi_nss_i;
      r_nss_s  <= r_nss_m;
      r_nss_d  <= r_nss_s;
      r_mosi_m <= spi_mosi_i;
      r_mosi_s <= r_mosi_m;
    end
  end

  // Frame FSM; mode and length are frozen for the whole active period
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_dtb   <= 2'b00;
    end else if (w_start) begin
      r_state <= S_ACTIVE;
      r_cpol  <= cpol_i;
      r_cpha  <= cpha_i;
      r_lsb   <= lsb_i;
      r_dtb   <= dtb_i;
    end else if (w_stop) begin
      r_state <= S_IDLE;
    end
  end

  // One-entry TX holding register, drained whenever the shift register reloads
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hold <= 32'd0;
      r_full <= 1'b0;
    end else if (w_load && r_full) begin
      r_full <= 1'b0;
    end else if (tx_valid_i && !r_full) begin
      r_hold <= tx_data_i;
      r_full <= 1'b1;
    end
  end

  // TX shift register; r_skip suppresses the one shift edge that would
  // otherwise consume bit 0 of a freshly loaded word (CPHA=1 first leading
  // edge, or the trailing edge that closes the previous frame with CPHA=0)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tx_sh <= 32'd0;
      r_skip  <= 1'b0;
      r_udr   <= 1'b0;
    end else begin
      r_udr <= 1'b0;
      if (w_stop) begin
        r_tx_sh <= 32'd0;
        r_skip  <= 1'b0;
      end else if (w_load) begin
        r_tx_sh <= w_load_word;
        r_skip  <= w_start ? cpha_i : 1'b1;
        r_udr   <= ~r_full;
      end else if (w_active && w_shift) begin
        if (r_skip)
          r_skip <= 1'b0;
        else if (r_lsb)
          r_tx_sh <= r_tx_sh >> 1;
        else
          r_tx_sh <= r_tx_sh << 1;
      end
    end
  end

  // RX shift register and bit counter; partial frames are dropped on stop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt   <= 6'd0;
      r_rx_sh <= 32'd0;
    end else if (w_start || w_stop || w_done) begin
      r_cnt   <= 6'd0;
      r_rx_sh <= 32'd0;
    end else if (w_smp) begin
      r_cnt   <= w_cnt_nxt;
      r_rx_sh <= w_rx_nxt;
    end
  end

  // RX output register with overrun detection; a same-cycle pop frees the slot
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 32'd0;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && r_rx_valid && !rx_ready_i) begin
        r_ovr <= 1'b1;
      end else if (w_done) begin
        r_rx_data  <= w_rx_nxt & w_mask;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready_o    = ~r_full;
  assign rx_valid_o    = r_rx_valid;
  assign rx_data_o     = r_rx_data;
  assign busy_o        = w_active;
  assign ovr_o         = r_ovr;
  assign udr_o         = r_udr;
  assign spi_miso_en_o = w_active;
  assign spi_miso_o    = r_lsb ? r_tx_sh[0] : r_tx_sh[w_msb_idx];

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives frames
// in each mode and results are compared against hand-computed words.
`timescale 1ns/1ps
module tb_spi_slave_core;

  localparam int H = 8;  // SCK half period in clk_i cycles

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic        cpol_i, cpha_i, lsb_i;
  logic [1:0]  dtb_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] tx_data_i;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] rx_data_o;
  logic        busy_o, ovr_o, udr_o;
  logic        spi_sck_i, spi_nss_i, spi_mosi_i;
  logic        spi_miso_o, spi_miso_en_o;

  int n_checks = 0;
  int n_fail   = 0;
  int udr_cnt  = 0;
  int ovr_cnt  = 0;

  logic [31:0] mi, mi2;

  spi_slave_core dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .en_i          (en_i),
    .cpol_i        (cpol_i),
    .cpha_i        (cpha_i),
    .lsb_i         (lsb_i),
    .dtb_i         (dtb_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .tx_data_i     (tx_data_i),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_data_o     (rx_data_o),
    .busy_o        (busy_o),
    .ovr_o         (ovr_o),
    .udr_o         (udr_o),
    .spi_sck_i     (spi_sck_i),
    .spi_nss_i     (spi_nss_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_en_o (spi_miso_en_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (udr_o) udr_cnt++;
    if (ovr_o) ovr_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_tx(input logic [31:0] d);
    @(negedge clk_i);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic nss_low();
    @(negedge clk_i);
    spi_nss_i = 1'b0;
    wait_clk(4);
  endtask

  task automatic nss_high();
    @(negedge clk_i);
    spi_nss_i = 1'b1;
    wait_clk(6);
  endtask

  // Master side of one frame: nbits clocks of an frm-bit frame
  task automatic spi_frame(input int nbits, input int frm, input logic cp, input logic ph,
                           input logic lsb, input logic [31:0] mo, output logic [31:0] rcv);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : frm - 1 - i;
      if (!ph) begin
        spi_mosi_i = mo[idx];
        wait_clk(H);
        r[idx] = spi_miso_o;
        spi_sck_i = ~cp;
        wait_clk(H);
        spi_sck_i = cp;
      end else begin
        wait_clk(H);
        spi_sck_i = ~cp;
        spi_mosi_i = mo[idx];
        wait_clk(H);
        r[idx] = spi_miso_o;
        spi_sck_i = cp;
      end
    end
    wait_clk(H);
    rcv = r;
  endtask

  initial begin
    rst_n_i = 1'b0; en_i = 1'b1;
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00;
    tx_valid_i = 1'b0; tx_data_i = 32'd0; rx_ready_i = 1'b0;
    spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
    wait_clk(4);

    // Reset state
    check("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("rst_rx_data", rx_data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_flags", {30'd0, ovr_o, udr_o}, 32'd0);
    check("rst_miso", {30'd0, spi_miso_en_o, spi_miso_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    wait_clk(4);

    // Mode 0, 8-bit, MSB-first; config changed mid-frame must be ignored
    push_tx(32'h0000_00A5);
    check("m0_tx_full", {31'd0, tx_ready_o}, 32'd0);
    nss_low();
    check("m0_busy", {30'd0, busy_o, spi_miso_en_o}, 32'd3);
    check("m0_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    dtb_i = 2'b11; lsb_i = 1'b1;
    spi_frame(8, 8, 1'b0, 1'b0, 1'b0, 32'h0000_003C, mi);
    nss_high();
    dtb_i = 2'b00; lsb_i = 1'b0;
    check("m0_miso_word", mi, 32'h0000_00A5);
    check("m0_rx_data", rx_data_o, 32'h0000_003C);
    wait_clk(10);
    check("m0_rx_hold", {31'd0, rx_valid_o}, 32'd1);
    pop_rx();
    check("m0_rx_popped", {31'd0, rx_valid_o}, 32'd0);

    // Modes 1..3, 32-bit, LSB-first
    for (int m = 1; m < 4; m++) begin
      cpol_i = m[1]; cpha_i = m[0]; lsb_i = 1'b1; dtb_i = 2'b11;
      spi_sck_i = m[1];
      wait_clk(4);
      push_tx(32'h1234_5678);
      udr_cnt = 0; ovr_cnt = 0;
      nss_low();
      push_tx(32'h0000_0000);
      spi_frame(32, 32, m[1], m[0], 1'b1, 32'hDEAD_BEEF, mi);
      nss_high();
      check($sformatf("mode%0d_miso_word", m), mi, 32'h1234_5678);
      check($sformatf("mode%0d_rx_data", m), rx_data_o, 32'hDEAD_BEEF);
      check($sformatf("mode%0d_rx_valid", m), {31'd0, rx_valid_o}, 32'd1);
      check($sformatf("mode%0d_no_flags", m), udr_cnt + ovr_cnt, 32'd0);
      pop_rx();
    end

    // Underrun and overrun: no preload, two back-to-back 8-bit frames
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0; dtb_i = 2'b00;
    spi_sck_i = 1'b0;
    wait_clk(4);
    udr_cnt = 0; ovr_cnt = 0;
    nss_low();
    check("udr_at_start", udr_cnt, 32'd1);
    spi_frame(8, 8, 1'b0, 1'b0, 1'b0, 32'h0000_0081, mi);
    spi_frame(8, 8, 1'b0, 1'b0, 1'b0, 32'h0000_007E, mi2);
    nss_high();
    check("udr_miso_f1", mi, 32'd0);
    check("udr_miso_f2", mi2, 32'd0);
    check("ovr_pulses", ovr_cnt, 32'd1);
    check("udr_pulses", udr_cnt, 32'd3);
    check("ovr_keep_data", rx_data_o, 32'h0000_0081);
    check("ovr_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    pop_rx();

    // Partial 16-bit frame aborted after 5 bits, then a full frame
    dtb_i = 2'b01;
    wait_clk(2);
    nss_low();
    spi_frame(5, 16, 1'b0, 1'b0, 1'b0, 32'h0000_BEEF, mi);
    nss_high();
    check("part_no_rx", {31'd0, rx_valid_o}, 32'd0);
    check("part_busy", {31'd0, busy_o}, 32'd0);
    push_tx(32'h0000_1234);
    nss_low();
    spi_frame(16, 16, 1'b0, 1'b0, 1'b0, 32'h0000_BEEF, mi);
    nss_high();
    check("part_next_rx", rx_data_o, 32'h0000_BEEF);
    check("part_next_miso", mi, 32'h0000_1234);

    // Asynchronous reset in the middle of a frame (rx word left unpopped)
    dtb_i = 2'b00;
    push_tx(32'h0000_0055);
    nss_low();
    spi_frame(3, 8, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, mi);
    push_tx(32'h0000_0066);
    check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    check("pre_rst_tx_full", {31'd0, tx_ready_o}, 32'd0);
    @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_busy", {30'd0, busy_o, spi_miso_en_o}, 32'd0);
    check("arst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    check("arst_rx", {31'd0, rx_valid_o}, 32'd0);
    check("arst_rx_data", rx_data_o, 32'd0);
    check("arst_flags", {29'd0, ovr_o, udr_o, spi_miso_o}, 32'd0);
    spi_nss_i = 1'b1;
    wait_clk(3);
    rst_n_i = 1'b1;
    wait_clk(4);
    check("post_rst_idle", {31'd0, busy_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
